// File: rtl/rx_lane_arbiter_if.sv
// rtl/rx_lane_arbiter_if.sv - lane inputs, controls and serialized output of rx_lane_arbiter
//   master : lane source / consumer side (drives data_rx*, valid_rx*, lane_en, ovf_clr, ready_out)
//   slave  : arbiter side (drives data_out, lane_out, valid_out, fifo_empty, fifo_full, ovf)
interface rx_lane_arbiter_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_rx0;
    logic [DATA_W-1:0] data_rx1;
    logic [DATA_W-1:0] data_rx2;
    logic [DATA_W-1:0] data_rx3;
    logic              valid_rx0;
    logic              valid_rx1;
    logic              valid_rx2;
    logic              valid_rx3;
    logic [3:0]        lane_en;
    logic [3:0]        ovf_clr;
    logic              ready_out;
    logic [DATA_W-1:0] data_out;
    logic [1:0]        lane_out;
    logic              valid_out;
    logic [3:0]        fifo_empty;
    logic [3:0]        fifo_full;
    logic [3:0]        ovf;

    modport master (
        output data_rx0, data_rx1, data_rx2, data_rx3,
        output valid_rx0, valid_rx1, valid_rx2, valid_rx3,
        output lane_en, ovf_clr, ready_out,
        input  data_out, lane_out, valid_out, fifo_empty, fifo_full, ovf
    );

    modport slave (
        input  data_rx0, data_rx1, data_rx2, data_rx3,
        input  valid_rx0, valid_rx1, valid_rx2, valid_rx3,
        input  lane_en, ovf_clr, ready_out,
        output data_out, lane_out, valid_out, fifo_empty, fifo_full, ovf
    );
endinterface

// File: rtl/rx_lane_arbiter.sv
// rtl/rx_lane_arbiter.sv - four-lane receive FIFOs serialized round-robin onto one ready/valid port
//   clk_f : sole clock, posedge
//   reset : synchronous, active-high
//   bus   : rx_lane_arbiter_if.slave (lane inputs, enables, ovf clear, output port, status)
module rx_lane_arbiter #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                 clk_f,
    input  logic                 reset,
    rx_lane_arbiter_if.slave     bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_W-1:0] r_mem [4][DEPTH];
    logic [PW-1:0]     r_wr  [4];
    logic [PW-1:0]     r_rd  [4];
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_lane;
    logic              r_valid;
    logic [1:0]        r_last;
    logic [3:0]        r_ovf;

    logic [DATA_W-1:0] w_din [4];
    logic [3:0]        w_vin;
    logic [3:0]        w_empty;
    logic [3:0]        w_full;
    logic [3:0]        w_elig;
    logic              w_load_ok;
    logic              w_win;
    logic [1:0]        w_gnt;
    logic [1:0]        w_cand;
    logic [3:0]        w_pop;
    logic [3:0]        w_push;
    logic [3:0]        w_drop;

    assign w_din[0] = bus.data_rx0;
    assign w_din[1] = bus.data_rx1;
    assign w_din[2] = bus.data_rx2;
    assign w_din[3] = bus.data_rx3;
    assign w_vin    = {bus.valid_rx3, bus.valid_rx2, bus.valid_rx1, bus.valid_rx0};

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    for (genvar g = 0; g < 4; g++) begin : g_status
        assign w_empty[g] = (r_wr[g] == r_rd[g]);
        assign w_full[g]  = (r_wr[g][AW] != r_rd[g][AW]) &&
                            (r_wr[g][AW-1:0] == r_rd[g][AW-1:0]);
    end

    assign w_elig    = ~w_empty & bus.lane_en;
    assign w_load_ok = !r_valid || bus.ready_out;

    // Search starts one past the last grant; k=4 wraps back to the last grant itself.
    always_comb begin
        w_win  = 1'b0;
        w_gnt  = r_last;
        w_cand = r_last;
        for (int k = 1; k <= 4; k++) begin
            w_cand = r_last + 2'(k);
            if (!w_win && w_elig[w_cand]) begin
                w_win = 1'b1;
                w_gnt = w_cand;
            end
        end
    end

    assign w_pop  = (w_load_ok && w_win) ? (4'b0001 << w_gnt) : 4'b0000;
    // A full lane still accepts when its head leaves this same edge.
    assign w_push = w_vin & bus.lane_en & (~w_full | w_pop);
    assign w_drop = w_vin & bus.lane_en & w_full & ~w_pop;

    always_ff @(posedge clk_f) begin
        for (int n = 0; n < 4; n++) begin
            if (w_push[n]) begin
                r_mem[n][r_wr[n][AW-1:0]] <= w_din[n];
            end
        end
    end

    always_ff @(posedge clk_f) begin
        if (reset) begin
            for (int n = 0; n < 4; n++) begin
                r_wr[n] <= '0;
                r_rd[n] <= '0;
            end
            r_data  <= '0;
            r_lane  <= 2'd0;
            r_valid <= 1'b0;
            r_last  <= 2'd3;
            r_ovf   <= 4'b0000;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (w_push[n]) begin
                    r_wr[n] <= r_wr[n] + PW'(1);
                end
                if (w_pop[n]) begin
                    r_rd[n] <= r_rd[n] + PW'(1);
                end
            end
            // A new drop outranks a same-cycle clear.
            r_ovf <= w_drop | (r_ovf & ~bus.ovf_clr);
            if (w_load_ok) begin
                if (w_win) begin
                    r_data  <= r_mem[w_gnt][r_rd[w_gnt][AW-1:0]];
                    r_lane  <= w_gnt;
                    r_valid <= 1'b1;
                    r_last  <= w_gnt;
                end else begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.data_out   = r_data;
    assign bus.lane_out   = r_lane;
    assign bus.valid_out  = r_valid;
    assign bus.fifo_empty = w_empty;
    assign bus.fifo_full  = w_full;
    assign bus.ovf        = r_ovf;
endmodule

// File: tb/tb_rx_lane_arbiter.sv
// tb/tb_rx_lane_arbiter.sv - scoreboard bench for rx_lane_arbiter
module tb_rx_lane_arbiter;
    logic clk_f = 1'b0;
    logic reset = 1'b1;

    rx_lane_arbiter_if #(.DATA_W(8)) bus ();

    rx_lane_arbiter #(.DATA_W(8), .DEPTH(4)) dut (
        .clk_f (clk_f),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk_f = ~clk_f;

    int n_vec = 0;
    int n_err = 0;
    logic [9:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a transfer happens at the next posedge when valid_out && ready_out.
    always @(negedge clk_f) begin
        if (!reset && bus.valid_out && bus.ready_out) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_out: got lane %0d data %0h expected none",
                         bus.lane_out, bus.data_out);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({bus.lane_out, bus.data_out} !== e) begin
                    n_err++;
                    $display("FAIL out_word: got lane %0d data %0h expected lane %0d data %0h",
                             bus.lane_out, bus.data_out, e[9:8], e[7:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_f);
        #1;
    endtask

    task automatic set_lane(input int n, input logic v, input logic [7:0] d);
        case (n)
            0: begin bus.valid_rx0 = v; bus.data_rx0 = d; end
            1: begin bus.valid_rx1 = v; bus.data_rx1 = d; end
            2: begin bus.valid_rx2 = v; bus.data_rx2 = d; end
            default: begin bus.valid_rx3 = v; bus.data_rx3 = d; end
        endcase
    endtask

    task automatic clear_lanes();
        for (int n = 0; n < 4; n++) set_lane(n, 1'b0, 8'h00);
    endtask

    task automatic push1(input int n, input logic [7:0] d);
        set_lane(n, 1'b1, d);
        step();
        clear_lanes();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        clear_lanes();
        bus.lane_en   = 4'hF;
        bus.ovf_clr   = 4'h0;
        bus.ready_out = 1'b0;

        // Reset then single word on lane 2
        do_reset();
        chk("rst_valid", 32'(bus.valid_out), 32'h0);
        chk("rst_data", 32'(bus.data_out), 32'h0);
        chk("rst_lane", 32'(bus.lane_out), 32'h0);
        chk("rst_empty", 32'(bus.fifo_empty), 32'hF);
        chk("rst_full", 32'(bus.fifo_full), 32'h0);
        chk("rst_ovf", 32'(bus.ovf), 32'h0);
        bus.ready_out = 1'b1;
        exp_q.push_back({2'd2, 8'hA5});
        push1(2, 8'hA5);
        chk("single_lat_valid", 32'(bus.valid_out), 32'h0);
        step();
        chk("single_valid", 32'(bus.valid_out), 32'h1);
        chk("single_data", 32'(bus.data_out), 32'hA5);
        chk("single_lane", 32'(bus.lane_out), 32'h2);
        step();
        chk("single_after_valid", 32'(bus.valid_out), 32'h0);
        chk("single_after_empty", 32'(bus.fifo_empty), 32'hF);

        // Round-robin across all lanes pushed on the same edge
        do_reset();
        bus.ready_out = 1'b1;
        exp_q.push_back({2'd0, 8'h10});
        exp_q.push_back({2'd1, 8'h20});
        exp_q.push_back({2'd2, 8'h30});
        exp_q.push_back({2'd3, 8'h40});
        set_lane(0, 1'b1, 8'h10);
        set_lane(1, 1'b1, 8'h20);
        set_lane(2, 1'b1, 8'h30);
        set_lane(3, 1'b1, 8'h40);
        step();
        clear_lanes();
        begin
            int cnt = 0;
            for (int i = 0; i < 4; i++) begin
                step();
                if (bus.valid_out) cnt++;
            end
            chk("rr_continuous", 32'(cnt), 32'd4);
        end
        step();
        chk("rr_done_valid", 32'(bus.valid_out), 32'h0);

        // Backpressure on lane 1
        do_reset();
        bus.ready_out = 1'b0;
        exp_q.push_back({2'd1, 8'h11});
        exp_q.push_back({2'd1, 8'h12});
        exp_q.push_back({2'd1, 8'h13});
        push1(1, 8'h11);
        step();
        chk("bp_valid", 32'(bus.valid_out), 32'h1);
        chk("bp_data0", 32'(bus.data_out), 32'h11);
        push1(1, 8'h12);
        chk("bp_data1", 32'(bus.data_out), 32'h11);
        push1(1, 8'h13);
        chk("bp_data2", 32'(bus.data_out), 32'h11);
        step();
        chk("bp_data3", 32'(bus.data_out), 32'h11);
        chk("bp_hold_valid", 32'(bus.valid_out), 32'h1);
        bus.ready_out = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("bp_drain_empty", 32'(bus.fifo_empty), 32'hF);
        chk("bp_drain_valid", 32'(bus.valid_out), 32'h0);

        // Overflow on lane 0 with the output register occupied
        do_reset();
        bus.ready_out = 1'b0;
        exp_q.push_back({2'd1, 8'h51});
        push1(1, 8'h51);
        step();
        chk("ovf_out_busy", 32'(bus.valid_out), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back({2'd0, 8'(i)});
            push1(0, 8'(i));
        end
        chk("ovf_full_after4", 32'(bus.fifo_full), 32'h1);
        chk("ovf_clear_before", 32'(bus.ovf), 32'h0);
        push1(0, 8'h05);
        chk("ovf_set", 32'(bus.ovf), 32'h1);
        chk("ovf_full_still", 32'(bus.fifo_full), 32'h1);
        bus.ovf_clr = 4'b0001;
        step();
        bus.ovf_clr = 4'b0000;
        chk("ovf_cleared", 32'(bus.ovf), 32'h0);
        bus.ready_out = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("ovf_drain_empty", 32'(bus.fifo_empty), 32'hF);

        // Full lane 3 accepting a push on the same edge it is popped
        do_reset();
        bus.ready_out = 1'b0;
        exp_q.push_back({2'd3, 8'h31});
        push1(3, 8'h31);
        for (int i = 2; i <= 5; i++) begin
            exp_q.push_back({2'd3, 8'h30 + 8'(i)});
            push1(3, 8'h30 + 8'(i));
        end
        chk("fp_full", 32'(bus.fifo_full), 32'h8);
        chk("fp_out31", 32'(bus.data_out), 32'h31);
        bus.ready_out = 1'b1;
        exp_q.push_back({2'd3, 8'hFF});
        push1(3, 8'hFF);
        chk("fp_no_ovf", 32'(bus.ovf), 32'h0);
        chk("fp_still_full", 32'(bus.fifo_full), 32'h8);
        chk("fp_out32", 32'(bus.data_out), 32'h32);
        for (int i = 0; i < 8; i++) step();
        chk("fp_drain_empty", 32'(bus.fifo_empty), 32'hF);

        // Disabled lane ignores input; reset discards buffered words
        do_reset();
        bus.lane_en   = 4'b1101;
        bus.ready_out = 1'b1;
        push1(1, 8'h77);
        chk("dis_empty", 32'(bus.fifo_empty), 32'hF);
        chk("dis_ovf", 32'(bus.ovf), 32'h0);
        step();
        chk("dis_no_out", 32'(bus.valid_out), 32'h0);
        bus.lane_en   = 4'hF;
        bus.ready_out = 1'b0;
        set_lane(0, 1'b1, 8'hC0);
        set_lane(2, 1'b1, 8'hC2);
        set_lane(3, 1'b1, 8'hC3);
        step();
        clear_lanes();
        step();
        chk("mid_valid", 32'(bus.valid_out), 32'h1);
        reset = 1'b1;
        step();
        chk("mid_rst_valid", 32'(bus.valid_out), 32'h0);
        chk("mid_rst_data", 32'(bus.data_out), 32'h0);
        chk("mid_rst_lane", 32'(bus.lane_out), 32'h0);
        chk("mid_rst_empty", 32'(bus.fifo_empty), 32'hF);
        chk("mid_rst_full", 32'(bus.fifo_full), 32'h0);
        chk("mid_rst_ovf", 32'(bus.ovf), 32'h0);
        reset = 1'b0;
        bus.ready_out = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_quiet", 32'(bus.valid_out), 32'h0);
        end

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
